i2s_mic_rx: RTL and testbench



---
 rtl/spec_audio_pkg.sv | 12 +
 rtl/i2s_dc_block.sv | 55 +++++
 rtl/i2s_mic_rx.sv | 111 +++++++++++
 tb/tb_i2s_mic_rx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spec_audio_pkg.sv
// Audio width and I2S framing constants shared by the microphone receiver and
// the display-side audio ring buffer.
package spec_audio_pkg;

   localparam int AUDIO_BITS    = 18;
   localparam int I2S_SLOT_BITS = 32;
   localparam int I2S_FRAME_BITS = 2 * I2S_SLOT_BITS;
   localparam int BCNT_BITS     = $clog2(I2S_FRAME_BITS);

   typedef logic signed [AUDIO_BITS-1:0] audio_sample_t;

endpackage

// File: rtl/i2s_dc_block.sv
// First-order DC-blocking high-pass: y = x - (acc >>> DC_SHIFT), acc += y,
// with y saturated to the signed OUT_BITS range. One register stage.
module i2s_dc_block
   import spec_audio_pkg::*;
#(
   parameter int OUT_BITS = AUDIO_BITS,
   parameter int DC_SHIFT = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic signed [OUT_BITS-1:0] in_data,
   output logic                       out_valid,
   output logic signed [OUT_BITS-1:0] out_data
);

   localparam int ACC_BITS = OUT_BITS + DC_SHIFT + 1;
   localparam logic signed [ACC_BITS-1:0] Y_MAX =
      ACC_BITS'((64'sd1 <<< (OUT_BITS - 1)) - 64'sd1);
   localparam logic signed [ACC_BITS-1:0] Y_MIN = -Y_MAX - ACC_BITS'(1);

   logic signed [ACC_BITS-1:0] acc;
   logic signed [ACC_BITS-1:0] x_ext;
   logic signed [ACC_BITS-1:0] diff;
   logic signed [ACC_BITS-1:0] y_ext;
   logic signed [OUT_BITS-1:0] y_sat;

   always_comb begin
      x_ext = {{(ACC_BITS - OUT_BITS){in_data[OUT_BITS-1]}}, in_data};
      diff  = x_ext - (acc >>> DC_SHIFT);
      y_sat = diff[OUT_BITS-1:0];
      if (diff > Y_MAX) begin
         y_sat = Y_MAX[OUT_BITS-1:0];
      end else if (diff < Y_MIN) begin
         y_sat = Y_MIN[OUT_BITS-1:0];
      end
      // The accumulator integrates the saturated value so it never runs away.
      y_ext = {{(ACC_BITS - OUT_BITS){y_sat[OUT_BITS-1]}}, y_sat};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= y_sat;
            acc      <= acc + y_ext;
         end
      end
   end

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S bus master for a MEMS microphone: SCK/WS generation, left-slot deserialiser
// and strobed sample output. Define I2S_RX_DCBLOCK_EN to insert the DC-block stage.
module i2s_mic_rx
   import spec_audio_pkg::*;
#(
   parameter int SCK_HALF  = 22,
   parameter int DATA_BITS = 24,
   parameter int OUT_BITS  = AUDIO_BITS,
   parameter int DC_SHIFT  = 10
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       I2S_SD,
   output logic                       I2S_SCK,
   output logic                       I2S_WS,
   output logic signed [OUT_BITS-1:0] ADATA0,
   output logic                       ADATARDY
);

   localparam int DIV_W = $clog2(SCK_HALF);

   if (SCK_HALF < 4) begin : g_bad_sck_half
      $error("SCK_HALF must be at least 4");
   end
   if (DATA_BITS > I2S_SLOT_BITS - 1 || OUT_BITS > DATA_BITS) begin : g_bad_widths
      $error("need OUT_BITS <= DATA_BITS <= 31");
   end
   if (DC_SHIFT < 1) begin : g_bad_dc_shift
      $error("DC_SHIFT must be at least 1");
   end

   logic [DIV_W-1:0]     div;
   logic [BCNT_BITS-1:0] bcnt;
   logic [BCNT_BITS-1:0] bcnt_nxt;
   logic [1:0]           sync;
   logic [DATA_BITS-1:0] shift;
   logic                 div_last;
   logic                 sck_fall;
   logic                 in_word;
   logic                 word_done;
   logic signed [OUT_BITS-1:0] x;
   logic signed [OUT_BITS-1:0] y;
   logic                 y_vld;

   // The last CLK of the SCK high phase is both the capture point and the
   // falling edge, so one strobe drives sampling, bcnt and WS together.
   assign div_last = (div == DIV_W'(SCK_HALF - 1));
   assign sck_fall = div_last & I2S_SCK;
   assign bcnt_nxt = bcnt + BCNT_BITS'(1);
   assign in_word  = (bcnt != '0) && (bcnt <= BCNT_BITS'(DATA_BITS));
   assign x        = shift[DATA_BITS-1 -: OUT_BITS];

   always_ff @(posedge CLK) begin
      if (RST) begin
         div       <= '0;
         I2S_SCK   <= 1'b0;
         I2S_WS    <= 1'b0;
         bcnt      <= '0;
         sync      <= '0;
         shift     <= '0;
         word_done <= 1'b0;
      end else begin
         div  <= div_last ? '0 : div + DIV_W'(1);
         sync <= {sync[0], I2S_SD};
         if (div_last) begin
            I2S_SCK <= ~I2S_SCK;
         end
         if (sck_fall) begin
            bcnt   <= bcnt_nxt;
            I2S_WS <= bcnt_nxt[BCNT_BITS-1];
         end
         if (sck_fall && in_word) begin
            shift <= {shift[DATA_BITS-2:0], sync[1]};
         end
         word_done <= sck_fall && (bcnt == BCNT_BITS'(DATA_BITS));
      end
   end

`ifdef I2S_RX_DCBLOCK_EN
   i2s_dc_block #(
      .OUT_BITS (OUT_BITS),
      .DC_SHIFT (DC_SHIFT)
   ) u_dc_block (
      .clk       (CLK),
      .rst       (RST),
      .in_valid  (word_done),
      .in_data   (x),
      .out_valid (y_vld),
      .out_data  (y)
   );
`else
   assign y_vld = word_done;
   assign y     = x;
`endif

   // Output protocol: ADATARDY is a one-CLK strobe with ADATA0 valid in the same
   // cycle; there is no ready, the consumer must take every strobe. ADATA0 holds
   // its value between strobes.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ADATA0   <= '0;
         ADATARDY <= 1'b0;
      end else begin
         ADATARDY <= y_vld;
         if (y_vld) begin
            ADATA0 <= y;
         end
      end
   end

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: I2S microphone model, strobe/clock monitor, directed and
// random frames checked against an arithmetic reference of the sample rules.
module tb_i2s_mic_rx;

   localparam int H     = 22;
   localparam int FRAME = 128 * H;
   localparam int FIRST = 50 * H;
`ifdef I2S_RX_DCBLOCK_EN
   localparam int LAT_X = 1;
`else
   localparam int LAT_X = 0;
`endif
   localparam int N = 12;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sd  = 1'b0;
   logic        sck;
   logic        ws;
   logic [17:0] adata;
   logic        rdy;

   int checks   = 0;
   int failures = 0;

   i2s_mic_rx dut (
      .CLK      (clk),
      .RST      (rst),
      .I2S_SD   (sd),
      .I2S_SCK  (sck),
      .I2S_WS   (ws),
      .ADATA0   (adata),
      .ADATARDY (rdy)
   );

   always #5 clk = ~clk;

   // posedge index since reset release: 0 is the first edge that samples RST low
   int edge_n = -1;
   always @(posedge clk) begin
      if (rst) edge_n = -1;
      else     edge_n++;
   end

   // microphone model: bit position restarts at every WS change, MSB one SCK later
   logic [23:0] left_w  = 24'h0;
   logic [23:0] right_w = 24'h0;
   bit          glitch_en = 1'b0;
   int          pos = 0;
   int          hi_cnt = 0;
   logic        mic_sck = 1'b0;
   logic        mic_ws  = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         pos = 0; sd = 1'b0; hi_cnt = 0; mic_sck = 1'b0; mic_ws = 1'b0;
      end else begin
         if (mic_sck && !sck) begin
            if (ws != mic_ws) pos = 0;
            else              pos++;
            mic_ws = ws;
            if (pos >= 1 && pos <= 24) sd = ws ? right_w[24-pos] : left_w[24-pos];
            else                       sd = 1'b0;
            hi_cnt = 0;
         end else if (sck) begin
            hi_cnt++;
            // corrupt SD only for the final CLK of the high phase
            if (glitch_en && hi_cnt == H) sd = ~sd;
         end
         mic_sck = sck;
      end
   end

   // monitor: strobe capture, strobe width, SCK timing and WS alignment
   int          obs_t[$];
   logic [17:0] obs_v[$];
   int   wide_cnt = 0, sck_bad = 0, ws_bad = 0, ws_toggles = 0;
   int   hi_run = 0, falls = 0, last_rise = -1;
   logic prev_rdy = 1'b0, m_sck = 1'b0, m_ws = 1'b0;

   always @(negedge clk) begin
      if (rdy && prev_rdy) wide_cnt++;
      if (rdy) begin
         obs_t.push_back(edge_n);
         obs_v.push_back(adata);
      end
      prev_rdy = rdy;
      if (rst) begin
         m_sck = 1'b0; m_ws = 1'b0; hi_run = 0; falls = 0; last_rise = -1;
      end else begin
         if (sck) hi_run++;
         if (!m_sck && sck) begin
            if (last_rise >= 0 && edge_n - last_rise != 2 * H) sck_bad++;
            last_rise = edge_n;
         end
         if (m_sck && !sck) begin
            if (hi_run != H) sck_bad++;
            hi_run = 0;
            falls++;
         end
         if (ws != m_ws) begin
            ws_toggles++;
            if (!(m_sck && !sck) || falls != 32) ws_bad++;
            falls = 0;
         end
         m_sck = sck;
         m_ws  = ws;
      end
   end

   // reference: left word as signed 24-bit, floor-divided by 64, optional DC block
   longint dc_acc = 0;

   function automatic logic [17:0] model(input logic [23:0] w);
      int v;
      int x;
      longint y;
      v = int'(w);
      if (w[23]) v = v - 16777216;
      x = v >>> 6;
`ifdef I2S_RX_DCBLOCK_EN
      y = longint'(x) - (dc_acc >>> 10);
      if (y > 131071)  y = 131071;
      if (y < -131072) y = -131072;
      dc_acc = dc_acc + y;
`else
      y = longint'(x);
`endif
      return y[17:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_strobe(output int t, output logic [17:0] v);
      int n;
      n = 0;
      while (obs_t.size() == 0 && n < FRAME + 200) begin
         @(negedge clk);
         n++;
      end
      if (obs_t.size() != 0) begin
         t = obs_t.pop_front();
         v = obs_v.pop_front();
      end else begin
         t = -1;
         v = 'x;
      end
   endtask

   logic [17:0] exp_q[$];
   logic [23:0] words[N];
   logic [23:0] rights[N];
   bit          glitches[N];

   initial begin
      int          t;
      int          t_prev;
      int          n;
      logic [17:0] v;

      words[0] = 24'h7FFFC0; rights[0] = 24'h123456;
      words[1] = 24'h7FFFC0; rights[1] = 24'h123456;
      words[2] = 24'h800000; rights[2] = 24'h123456;
      words[3] = 24'h000040; rights[3] = 24'h7FFFFF;
      words[4] = 24'h00003F; rights[4] = 24'h800000;
      for (int i = 0; i < N; i++) glitches[i] = 1'b0;
      for (int i = 5; i < N; i++) begin
         words[i]  = 24'($urandom_range(0, 24'hFFFFFF));
         rights[i] = 24'($urandom_range(0, 24'hFFFFFF));
      end
      glitches[N-1] = 1'b1;

      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_sck", 32'(sck), 0);
      chk("rst_ws", 32'(ws), 0);
      chk("rst_adata", 32'(adata), 0);
      chk("rst_rdy", 32'(rdy), 0);

      left_w  = words[0];
      right_w = rights[0];
      exp_q.push_back(model(words[0]));
      rst = 1'b0;

      t_prev = 0;
      for (int k = 0; k < N; k++) begin
         wait_strobe(t, v);
         if (k + 1 < N) begin
            left_w    = words[k+1];
            right_w   = rights[k+1];
            glitch_en = glitches[k+1];
            exp_q.push_back(model(words[k+1]));
         end
         if (k == 0) chk("first_strobe_cycle", 32'(t), 32'(FIRST + LAT_X));
         else        chk("strobe_period", 32'(t - t_prev), 32'(FRAME));
         chk($sformatf("sample_%0d", k), 32'(v), 32'(exp_q.pop_front()));
         t_prev = t;
      end

      // reset in the middle of a left slot: the partial word must vanish
      glitch_en = 1'b0;
      left_w    = 24'h7FFFC0;
      n = 0;
      while (!(pos == 10 && ws == 1'b0) && n < 2 * FRAME) begin
         @(negedge clk);
         n++;
      end
      chk("reach_bcnt10", 32'(pos == 10 && ws == 1'b0), 1);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      dc_acc  = 0;
      left_w  = 24'h5A5A40;
      right_w = 24'hFFFFFF;
      exp_q.push_back(model(24'h5A5A40));
      rst = 1'b0;
      wait_strobe(t, v);
      chk("strobe_after_reset", 32'(t), 32'(FIRST + LAT_X));
      chk("sample_after_reset", 32'(v), 32'(exp_q.pop_front()));

      repeat (4 * H) @(negedge clk);
      chk("strobe_width", 32'(wide_cnt), 0);
      chk("sck_timing", 32'(sck_bad), 0);
      chk("ws_alignment", 32'(ws_bad), 0);
      chk("ws_activity", 32'(ws_toggles >= 20), 1);
      chk("no_extra_strobes", 32'(obs_t.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
